// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Default bit time: 25 MHz system clock / 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 217;

    // Frame shape: 8 data bits, no parity, 1 stop bit.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte request / serial status bundle between a byte producer and uart_tx.
// Latency: n/a (wires only).
// Backpressure: none; requests arriving while o_TX_Active is high are dropped.
//   i_TX_DV     request strobe, qualifies i_TX_Byte
//   i_TX_Byte   byte to send
//   o_TX_Active frame in progress
//   o_TX_Serial serial line, idles high
//   o_TX_Done   one-cycle pulse after the stop bit
interface uart_tx_if;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Active;
    logic       o_TX_Serial;
    logic       o_TX_Done;

    // Producer side.
    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Active,
        input  o_TX_Serial,
        input  o_TX_Done
    );

    // Transmitter side.
    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Active,
        output o_TX_Serial,
        output o_TX_Done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: o_Bit_End is high during the CLKS_PER_BIT-th cycle after a clear.
// Backpressure: none; free-running unless held in clear.
//   i_Clock, i_Rst_n  clock and async active-low reset
//   i_Clear           hold the count at zero
//   o_Bit_End         one-cycle flag on the final cycle of a bit period
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Clear,
    output logic o_Bit_End
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_Count;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Count <= '0;
        end else if (i_Clear || (r_Count == CNT_LAST)) begin
            r_Count <= '0;
        end else begin
            r_Count <= r_Count + 1'b1;
        end
    end

    assign o_Bit_End = (r_Count == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, 8 data bits LSB first, one stop bit.
// Latency: line goes low on the accepting edge; frame lasts 10*CLKS_PER_BIT cycles, Done pulses on the last edge.
// Backpressure: none; i_TX_DV is ignored (dropped) while a frame is in progress or on the Done edge.
//   i_Clock, i_Rst_n  clock and async active-low reset
//   tx_bus            request strobe/byte in, Active/Serial/Done out (all outputs registered)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    uart_tx_if.slave   tx_bus
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_t r_State, state_d;
    logic [7:0]  r_Data,  data_d;
    logic [2:0]  r_Idx,   idx_d;
    logic        r_Serial, serial_d;
    logic        r_Active, active_d;
    logic        r_Done,   done_d;
    logic        bit_end;

    // The timer sits at zero while idle, so the accepting edge starts a fresh bit period.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clock   (i_Clock),
        .i_Rst_n   (i_Rst_n),
        .i_Clear   (r_State == IDLE),
        .o_Bit_End (bit_end)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State  <= IDLE;
            r_Data   <= '0;
            r_Idx    <= '0;
            r_Serial <= 1'b1;
            r_Active <= 1'b0;
            r_Done   <= 1'b0;
        end else begin
            r_State  <= state_d;
            r_Data   <= data_d;
            r_Idx    <= idx_d;
            r_Serial <= serial_d;
            r_Active <= active_d;
            r_Done   <= done_d;
        end
    end

    // Next-state logic computes the value each output takes after the edge,
    // so the line changes exactly on the bit boundaries.
    always_comb begin
        state_d  = r_State;
        data_d   = r_Data;
        idx_d    = r_Idx;
        serial_d = r_Serial;
        active_d = r_Active;
        done_d   = 1'b0;

        unique case (r_State)
            IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                if (tx_bus.i_TX_DV) begin
                    data_d   = tx_bus.i_TX_Byte;
                    idx_d    = '0;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d    = '0;
                    serial_d = r_Data[0];
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (r_Idx == LAST_IDX) begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        idx_d    = r_Idx + 3'd1;
                        serial_d = r_Data[r_Idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_bus.o_TX_Serial = r_Serial;
    assign tx_bus.o_TX_Active = r_Active;
    assign tx_bus.o_TX_Done   = r_Done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one instance at the default bit time, one at 4 clocks per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx;

    localparam int NA = 217;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #20 clk = ~clk;

    uart_tx_if ifa ();
    uart_tx_if ifb ();

    uart_tx #(.CLKS_PER_BIT(NA)) dut_a (
        .i_Clock (clk),
        .i_Rst_n (rst_a),
        .tx_bus  (ifa.slave)
    );

    uart_tx #(.CLKS_PER_BIT(NB)) dut_b (
        .i_Clock (clk),
        .i_Rst_n (rst_b),
        .tx_bus  (ifb.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Expected line per frame slot, slot 0 (start bit) in the MSB.
    typedef struct {
        bit         sel;      // 0: instance A (N=217), 1: instance B (N=4)
        logic [7:0] data;
        logic [9:0] exp_line;
        int         inj_t;    // cycle offset of an extra DV pulse, -1 for none
        logic [7:0] inj_b;
        bit         chain;    // next entry is requested on the first legal edge
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input bit sel, input logic dv, input logic [7:0] b);
        if (sel) begin
            ifb.i_TX_DV = dv;
            ifb.i_TX_Byte = b;
        end else begin
            ifa.i_TX_DV = dv;
            ifa.i_TX_Byte = b;
        end
    endtask

    task automatic sample(input bit sel, output logic s, output logic a, output logic d);
        s = sel ? ifb.o_TX_Serial : ifa.o_TX_Serial;
        a = sel ? ifb.o_TX_Active : ifa.o_TX_Active;
        d = sel ? ifb.o_TX_Done   : ifa.o_TX_Done;
    endtask

    // Reference frame: start 0, data bits LSB first, stop 1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] r;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      r[9-k] = 1'b0;
            else if (k <= 8) r[9-k] = b[k-1];
            else             r[9-k] = 1'b1;
        end
        return r;
    endfunction

    // Called with DV already driven for the accepting edge. Samples on negedges
    // for offsets t = 0..10N after the accepting edge E0.
    task automatic check_frame(input bit sel, input int n, input logic [9:0] exp,
                               input int inj_t, input logic [7:0] inj_b,
                               input bit chain, input logic [7:0] nxt);
        int slot_good[10];
        int act_cnt;
        int done_cnt;
        logic s, a, d;
        logic [9:0] e;
        e = exp;
        act_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) slot_good[k] = 0;
        @(posedge clk);
        for (int t = 0; t <= 10*n; t++) begin
            @(negedge clk);
            sample(sel, s, a, d);
            if (t < 10*n) begin
                if (s == e[9 - t/n]) slot_good[t/n]++;
            end else begin
                check("line_high_after_stop", int'(s), 1);
                check("active_low_after_stop", int'(a), 0);
                check("done_after_stop", int'(d), 1);
            end
            act_cnt += int'(a);
            done_cnt += int'(d);
            if (chain && t == 10*n)  set_in(sel, 1'b1, nxt);
            else if (t == inj_t)     set_in(sel, 1'b1, inj_b);
            else                     set_in(sel, 1'b0, 8'($urandom));
        end
        for (int k = 0; k < 10; k++)
            check($sformatf("slot%0d_cycles(byte=%02h)", k, exp), slot_good[k], n);
        check("active_cycles", act_cnt, 10*n);
        check("done_pulses", done_cnt, 1);
    endtask

    task automatic check_idle(input bit sel, input int cycles);
        int good;
        logic s, a, d;
        good = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            sample(sel, s, a, d);
            if (s == 1'b1 && a == 1'b0 && d == 1'b0) good++;
            set_in(sel, 1'b0, 8'($urandom));
        end
        check("idle_cycles", good, cycles);
    endtask

    vec_t tbl[7];
    logic s, a, d;
    logic [7:0] rb;
    bit chained;

    initial begin
        // 0xAA at the default bit time, then the N=4 scenarios.
        tbl[0] = '{1'b0, 8'hAA, 10'b0010101011, -1, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h3F, 10'b0111111001, -1, 8'h00, 1'b0};
        // DV with 0x00 during data bit 2 must be dropped.
        tbl[2] = '{1'b1, 8'h55, 10'b0101010101, 14, 8'h00, 1'b0};
        // Back-to-back: 0xFF requested at E0+41.
        tbl[3] = '{1'b1, 8'h01, 10'b0100000001, -1, 8'h00, 1'b1};
        tbl[4] = '{1'b1, 8'hFF, 10'b0111111111, -1, 8'h00, 1'b0};
        // DV present at the Done edge E0+10N must be ignored.
        tbl[5] = '{1'b1, 8'h00, 10'b0000000001, 39, 8'h5A, 1'b0};
        tbl[6] = '{1'b1, 8'h80, 10'b0000000011, -1, 8'h00, 1'b0};

        set_in(1'b0, 1'b0, 8'h00);
        set_in(1'b1, 1'b0, 8'h00);

        // Reset state, held and then released.
        repeat (3) @(negedge clk);
        sample(1'b0, s, a, d);
        check("rst_a_serial", int'(s), 1);
        check("rst_a_active", int'(a), 0);
        check("rst_a_done", int'(d), 0);
        sample(1'b1, s, a, d);
        check("rst_b_serial", int'(s), 1);
        check("rst_b_active", int'(a), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        check_idle(1'b0, 3);
        check_idle(1'b1, 3);

        // Table-driven frames.
        chained = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!chained) begin
                @(negedge clk);
                set_in(tbl[i].sel, 1'b1, tbl[i].data);
            end
            check_frame(tbl[i].sel, tbl[i].sel ? NB : NA, tbl[i].exp_line,
                        tbl[i].inj_t, tbl[i].inj_b, tbl[i].chain,
                        (tbl[i].chain && i < 6) ? tbl[i+1].data : 8'h00);
            chained = tbl[i].chain;
            if (!chained) check_idle(tbl[i].sel, 4);
        end

        // Randomized frames against the reference model, some back-to-back.
        chained = 1'b0;
        rb = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] nb;
            bit ch;
            nb = 8'($urandom);
            ch = ($urandom_range(0, 1) == 1) && (i < 11);
            if (!chained) begin
                @(negedge clk);
                set_in(1'b1, 1'b1, rb);
            end
            check_frame(1'b1, NB, model_frame(rb), -1, 8'h00, ch, nb);
            if (!ch) check_idle(1'b1, 2);
            chained = ch;
            rb = nb;
        end

        // Mid-frame reset during data bits of 0x00 (line low).
        @(negedge clk);
        set_in(1'b1, 1'b1, 8'h00);
        @(posedge clk);
        for (int t = 0; t <= 2*NB + 1; t++) begin
            @(negedge clk);
            set_in(1'b1, 1'b0, 8'($urandom));
        end
        sample(1'b1, s, a, d);
        check("pre_reset_line", int'(s), 0);
        check("pre_reset_active", int'(a), 1);
        #5 rst_b = 1'b0;
        #1 sample(1'b1, s, a, d);
        check("async_reset_line", int'(s), 1);
        check("async_reset_active", int'(a), 0);
        check("async_reset_done", int'(d), 0);
        check_idle(1'b1, 3);
        rst_b = 1'b1;
        check_idle(1'b1, 4 * NB + 4);
        @(negedge clk);
        set_in(1'b1, 1'b1, 8'hC3);
        check_frame(1'b1, NB, model_frame(8'hC3), -1, 8'h00, 1'b0, 8'h00);
        check_idle(1'b1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit-only UART serializer. Sends one 8-bit byte per request as an 8N1 frame: one start bit (low), eight data bits LSB first, one stop bit (high), no parity. Bit time is a fixed number of system clocks set by parameter. It sits between a byte-producing controller and the board TX pin.

## Interface
- CLKS_PER_BIT, 217, system clocks per serial bit (25 MHz / 115200 baud); legal range ≥ 2.
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_TX_DV  in  1  one-cycle request strobe; qualifies i_TX_Byte.
- i_TX_Byte  in  8  byte to send, sampled only when the request is accepted.
- o_TX_Active  out  1  high while a frame is in progress.
- o_TX_Serial  out  1  serial line; idles high.
- o_TX_Done  out  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: o_TX_Serial=1, o_TX_Active=0.
  - If i_TX_DV=1 at an edge, latch i_TX_Byte into an internal shift/data register.
  - On that edge set o_TX_Active=1, drive o_TX_Serial=0, clear the clock counter, and go to START.
- START: hold the line low for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: drive latched bit[index] for CLKS_PER_BIT cycles each, for indices 0..7. After index 7, go to STOP.
- STOP: drive the line high for CLKS_PER_BIT cycles. On the final edge, go to IDLE, set o_TX_Active=0, and pulse o_TX_Done=1 for exactly one cycle.
- i_TX_DV is ignored in START, DATA and STOP. No queuing; the dropped request leaves no side effect.
- i_TX_Byte changes after acceptance do not affect the frame in flight.
- Clock counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- The bit index is 3 bits.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, state IDLE, counters 0. These apply immediately on i_Rst_n falling.
- Reset mid-frame aborts the frame; the line returns high at once and no Done pulse is produced.
- Let E0 be the accepting edge and N = CLKS_PER_BIT:
  - Start bit occupies [E0, E0+N).
  - Data bit i occupies [E0+(1+i)N, E0+(2+i)N).
  - Stop bit occupies [E0+9N, E0+10N).
- At edge E0+10N: o_TX_Active falls and o_TX_Done rises. At E0+10N+1, o_TX_Done falls.
- Total frame: 10N cycles of line time.
- The earliest next request is accepted at edge E0+10N+1 (the Done cycle is spent in IDLE). A DV present at E0+10N itself is ignored.
- Back-to-back accepted requests give frames separated by exactly one idle-high cycle.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP);
  - default CLKS_PER_BIT constant;
  - frame constants: data bits = 8, stop bits = 1.
- One natural sub-module, `uart_bit_timer`, parameterized by CLKS_PER_BIT:
  - clears on an external clear;
  - asserts a one-cycle bit_end when the count reaches N-1, then wraps.
- The FSM, data register, bit index and outputs live in uart_tx.

## Test plan
- Reset: hold i_Rst_n=0 → o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0. Release → outputs unchanged.
- Send 0xAA with default N=217 and a 40 ns clock:
  - line sequence 0,0,1,0,1,0,1,0,1,1, each bit 217 cycles (8.68 µs);
  - o_TX_Active high for 2170 cycles;
  - o_TX_Done high for exactly 1 cycle at E0+2170.
- Send 0x3F with N=4: line 0,1,1,1,1,1,1,0,0,1 (4 cycles each), then idle high.
- Busy rejection: with N=4, send 0x55, then pulse DV with 0x00 mid-DATA → the frame remains 0x55 and no second frame starts.
- Back-to-back: with N=4, send 0x01, then assert DV with 0xFF at E0+41 → second start bit begins at E0+41, with one idle cycle between stop and start.
- Mid-frame reset: with N=4, drop i_Rst_n during DATA → line goes high asynchronously, Active=0, no Done. The next request sends a full, correct frame.
